pq_sched: RTL and testbench
===========================

# pq_sched

Arbitration and sequencing controller for the 6-entry sorted priority queue. It grants one of NREQ producers an insert slot and arbitrates inserts against a single consumer's pop requests. It tracks occupancy so the queue is never overfilled or popped while empty, and issues synchronous flushes. It sits between the producer/consumer logic and the queue, and drives the queue's newVal, loadIn, shiftOut and clear pins directly.

## Interface
- W, 8, value width; matches the queue's W
- DEPTH, 6, queue capacity; fixed by the queue datapath
- NREQ, 4, number of insert requesters
- ck  in  1  clock; all state changes on posedge
- r  in  1  reset; asynchronous, active-high
- req  in  NREQ  per-requester insert request; held until granted
- req_val  in  NREQ*W  request values; requester i occupies bits [i*W +: W]
- grant  out  NREQ  one-hot; grant[i]=1 for the cycle in which req_val[i] is taken
- pop_req  in  1  consumer pop request; held until pop_ack
- pop_ack  out  1  pop accepted this cycle
- pop_valid  out  1  one-cycle pulse; pop_val holds the popped value
- pop_val  out  W  popped value, registered
- flush  in  1  synchronous request to empty the queue
- pq_top  in  W  queue head value
- pq_newVal  out  W  value presented to the queue
- pq_loadIn  out  1  queue insert strobe
- pq_shiftOut  out  1  queue pop strobe
- pq_clear  out  1  queue clear strobe
- count  out  3  current occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0

## Operation
- Two FSM states: RUN and FLUSH.
- In RUN with flush=1:
  - Go to FLUSH. No grant or pop_ack is issued this cycle.
- In FLUSH:
  - pq_clear=1 for exactly one cycle.
  - count<=0 and the arbitration state is unchanged.
  - Return to RUN.
  - flush is ignored while in FLUSH.
- Insert eligibility (RUN): any req bit is set and !full.
- Pop eligibility (RUN): pop_req && !empty.
- At most one queue operation per cycle, because the queue cannot insert and shift together.
- When both are eligible, a registered bit last_op decides:
  - Pop wins if last_op=INSERT; otherwise insert wins.
  - last_op updates only on cycles where an operation issues.
  - Result: inserts and pops strictly alternate under contention.
- Requester selection is round-robin:
  - Pointer rr (log2 NREQ bits, reset 0).
  - Search starts at rr; the first set req bit wins.
  - On grant to i, rr<=(i+1) mod NREQ. rr is unchanged when nothing is granted.
- Insert issue:
  - grant[i]=1, pq_newVal=req_val[i], pq_loadIn=1, count<=count+1.
- Zero-valued insert:
  - The value 0 is the queue's empty marker and would be silently dropped.
  - Requester is granted (grant[i]=1) but pq_loadIn=0, count unchanged, rr still advances.
- Pop issue:
  - pop_ack=1, pq_shiftOut=1, count<=count-1.
  - pop_val<=pq_top and pop_valid<=1 on the same edge.
- pq_newVal when no insert issues: 0.
- All control outputs to the queue (pq_loadIn, pq_shiftOut, pq_clear) are mutually exclusive.

## Timing
- Reset values:
  - State: state=RUN, count=0, rr=0, last_op=POP (so the first contention goes to insert).
  - Outputs: pop_val=0, pop_valid=0, grant=0, pop_ack=0, pq_* strobes=0, empty=1, full=0.
- Reset asserted mid-operation: all state is forced to reset values immediately and asynchronously. No strobe survives. The queue is reset by the same r.
- Timing of outputs:
  - grant, pop_ack and pq_* are combinational from registered state and inputs in the same cycle.
  - The queue updates at the following edge.
- Insert latency: grant cycle N means the value is visible in the queue (and, if largest, on pq_top) after edge N+1.
- Pop latency: pop_ack in cycle N means pop_valid=1 and pop_val=old head in cycle N+1.
- Back-to-back pops are allowed every cycle while !empty. pq_top is the new head after each edge.
- Boundary conditions:
  - full: requests are held with no grant. A pop in the same cycle is still allowed, and requests are eligible the next cycle.
  - empty: pop_req is held with no ack.
  - flush raised the same cycle as a request: flush wins, and the request is serviced after FLUSH.

## Test plan
- Reset then idle: after r deasserts, count=0, empty=1, and all strobes stay 0 for 10 cycles with no requests.
- Sorted fill and drain:
  - Single requester inserts 5, 9, 2, 7.
  - Then pop_req held until empty.
  - Pops return 9, 7, 5, 2 with pop_valid one cycle after each pop_ack; count ends 0.
- Full backpressure:
  - Insert 6 nonzero values; full=1.
  - A 7th req gets no grant.
  - A pop in that cycle is accepted, and the 7th req is granted the following cycle.
- Round-robin fairness:
  - All 4 req held with distinct values, no pops.
  - Grant order is 0, 1, 2, 3, then 0 again once space exists.
- Insert/pop contention:
  - Queue holds 3; req and pop_req held continuously.
  - Operations alternate insert, pop, insert, pop…, starting with insert after reset.
- Flush, zero value, and async reset:
  - flush with count=4: one pq_clear cycle, then count=0.
  - Insert of 0: grant issued, count unchanged.
  - r asserted mid-pop: pop_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/pq_sched.sv
// rtl/pq_sched.sv - insert/pop arbitration and occupancy tracking for the 6-entry sorted queue
module pq_sched #(
    parameter int W     = 8,
    parameter int DEPTH = 6,
    parameter int NREQ  = 4
) (
    input  logic              ck,
    input  logic              r,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_val,
    output logic [NREQ-1:0]   grant,
    input  logic              pop_req,
    output logic              pop_ack,
    output logic              pop_valid,
    output logic [W-1:0]      pop_val,
    input  logic              flush,
    input  logic [W-1:0]      pq_top,
    output logic [W-1:0]      pq_newVal,
    output logic              pq_loadIn,
    output logic              pq_shiftOut,
    output logic              pq_clear,
    output logic [2:0]        count,
    output logic              full,
    output logic              empty
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic OP_POP    = 1'b0;
    localparam logic OP_INSERT = 1'b1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     count_q, count_d;
    logic [RRW-1:0] rr_q, rr_d;
    logic           last_op_q, last_op_d;
    logic [W-1:0]   pop_val_q, pop_val_d;
    logic           pop_valid_q, pop_valid_d;

    logic           sel_found;
    logic [RRW-1:0] sel_idx;
    logic [W-1:0]   sel_val;
    int             cand;
    logic           ins_elig;
    logic           pop_elig;
    logic           do_pop;
    logic           do_ins;

    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 3'd0);
    assign pop_val   = pop_val_q;
    assign pop_valid = pop_valid_q;

    // Round-robin search: first set request at or after rr, wrapping.
    always_comb begin : rr_select
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_q) + k) % NREQ;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = RRW'(cand);
            end
        end
    end

    assign sel_val  = req_val[sel_idx*W +: W];
    assign ins_elig = sel_found && !full;
    assign pop_elig = pop_req && !empty;
    // Under contention the side that did not go last wins, so the two alternate.
    assign do_pop   = pop_elig && (!ins_elig || (last_op_q == OP_INSERT));
    assign do_ins   = ins_elig && !do_pop;

    always_comb begin : next_state
        state_d     = state_q;
        count_d     = count_q;
        rr_d        = rr_q;
        last_op_d   = last_op_q;
        pop_val_d   = pop_val_q;
        pop_valid_d = 1'b0;
        grant       = '0;
        pop_ack     = 1'b0;
        pq_newVal   = '0;
        pq_loadIn   = 1'b0;
        pq_shiftOut = 1'b0;
        pq_clear    = 1'b0;

        if (!r) begin
            case (state_q)
                RUN: begin
                    if (flush) begin
                        state_d = FLUSH;
                    end else if (do_ins) begin
                        grant[sel_idx] = 1'b1;
                        rr_d           = RRW'((int'(sel_idx) + 1) % NREQ);
                        last_op_d      = OP_INSERT;
                        // Zero is the queue's empty marker: grant it but never load it.
                        if (sel_val != '0) begin
                            pq_newVal = sel_val;
                            pq_loadIn = 1'b1;
                            count_d   = count_q + 3'd1;
                        end
                    end else if (do_pop) begin
                        pop_ack     = 1'b1;
                        pq_shiftOut = 1'b1;
                        count_d     = count_q - 3'd1;
                        pop_val_d   = pq_top;
                        pop_valid_d = 1'b1;
                        last_op_d   = OP_POP;
                    end
                end
                FLUSH: begin
                    pq_clear = 1'b1;
                    count_d  = 3'd0;
                    state_d  = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            state_q     <= RUN;
            count_q     <= 3'd0;
            rr_q        <= '0;
            last_op_q   <= OP_POP;
            pop_val_q   <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            last_op_q   <= last_op_d;
            pop_val_q   <= pop_val_d;
            pop_valid_q <= pop_valid_d;
        end
    end

endmodule

// File: tb/tb_pq_sched.sv
// tb/tb_pq_sched.sv - pq_sched bench: sorted-queue environment, list-based reference model, directed and random stimulus
module tb_pq_sched;
    localparam int W = 8;
    localparam int DEPTH = 6;
    localparam int NREQ = 4;

    logic              ck = 1'b0;
    logic              r;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_val;
    logic [NREQ-1:0]   grant;
    logic              pop_req, pop_ack, pop_valid;
    logic [W-1:0]      pop_val;
    logic              flush;
    logic [W-1:0]      pq_top, pq_newVal;
    logic              pq_loadIn, pq_shiftOut, pq_clear;
    logic [2:0]        count;
    logic              full, empty;

    always #5 ck = ~ck;

    pq_sched #(.W(W), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .ck(ck), .r(r), .req(req), .req_val(req_val), .grant(grant),
        .pop_req(pop_req), .pop_ack(pop_ack), .pop_valid(pop_valid), .pop_val(pop_val),
        .flush(flush), .pq_top(pq_top), .pq_newVal(pq_newVal), .pq_loadIn(pq_loadIn),
        .pq_shiftOut(pq_shiftOut), .pq_clear(pq_clear), .count(count), .full(full), .empty(empty)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qmax_idx(input int q[$]);
        int best = -1;
        foreach (q[i]) if (best < 0 || q[i] > q[best]) best = i;
        return best;
    endfunction

    // Sorted queue stand-in: head is the largest held value, 0 when empty.
    int envq[$];
    always @(posedge ck or posedge r) begin : env
        int mi;
        if (r) begin
            envq.delete();
            pq_top <= '0;
        end else begin
            if (pq_clear) envq.delete();
            else if (pq_loadIn && pq_newVal != 0 && envq.size() < DEPTH) envq.push_back(int'(pq_newVal));
            else if (pq_shiftOut && envq.size() > 0) begin
                mi = qmax_idx(envq);
                envq.delete(mi);
            end
            mi = qmax_idx(envq);
            pq_top <= (mi < 0) ? '0 : W'(envq[mi]);
        end
    end

    // Reference model: the queue contents are a plain list; occupancy is its size.
    int mlist[$];
    int m_rr = 0;
    bit m_last_ins = 0;
    bit m_flushing = 0;
    bit m_pv = 0;
    int m_pval = 0;

    int grant_log[$];
    int pop_log[$];
    int op_log[$];
    int clear_cnt = 0;
    int strobe_cnt = 0;

    always @(negedge ck) begin : cmp
        int w, v, mi, eg, enl;
        bit ins_ok, pop_ok, dpop, dins, eack, eld, esh, ecl;
        for (int i = 0; i < NREQ; i++) if (grant[i]) grant_log.push_back(i);
        if (grant != 0) op_log.push_back(1);
        if (pop_ack) op_log.push_back(2);
        if (pop_valid) pop_log.push_back(int'(pop_val));
        if (pq_clear) clear_cnt++;
        if (pq_loadIn || pq_shiftOut || pq_clear) strobe_cnt++;
        if (r) begin
            mlist.delete();
            m_rr = 0; m_last_ins = 0; m_flushing = 0; m_pv = 0; m_pval = 0;
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
            chk("rst_pop_valid", int'(pop_valid), 0);
            chk("rst_pop_val", int'(pop_val), 0);
            chk("rst_grant", int'(grant), 0);
            chk("rst_strobes", int'({pop_ack, pq_loadIn, pq_shiftOut, pq_clear}), 0);
        end else begin
            chk("count", int'(count), mlist.size());
            chk("empty", int'(empty), int'(mlist.size() == 0));
            chk("full", int'(full), int'(mlist.size() == DEPTH));
            chk("pop_valid", int'(pop_valid), int'(m_pv));
            if (m_pv) chk("pop_val", int'(pop_val), m_pval);
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            v = (w < 0) ? 0 : int'(req_val[w*W +: W]);
            ins_ok = (w >= 0) && (mlist.size() < DEPTH);
            pop_ok = pop_req && (mlist.size() > 0);
            dpop = !m_flushing && !flush && pop_ok && (!ins_ok || m_last_ins);
            dins = !m_flushing && !flush && ins_ok && !dpop;
            eg = dins ? (1 << w) : 0;
            eld = dins && (v != 0);
            enl = eld ? v : 0;
            eack = dpop; esh = dpop; ecl = m_flushing;
            chk("grant", int'(grant), eg);
            chk("pop_ack", int'(pop_ack), int'(eack));
            chk("pq_loadIn", int'(pq_loadIn), int'(eld));
            chk("pq_shiftOut", int'(pq_shiftOut), int'(esh));
            chk("pq_clear", int'(pq_clear), int'(ecl));
            chk("pq_newVal", int'(pq_newVal), enl);
            m_pv = 0;
            if (m_flushing) begin
                mlist.delete();
                m_flushing = 0;
            end else if (flush) begin
                m_flushing = 1;
            end else if (dins) begin
                if (v != 0) mlist.push_back(v);
                m_rr = (w + 1) % NREQ;
                m_last_ins = 1;
            end else if (dpop) begin
                mi = qmax_idx(mlist);
                m_pval = mlist[mi];
                mlist.delete(mi);
                m_pv = 1;
                m_last_ins = 0;
            end
        end
    end

    task automatic do_insert(input int i, input int v);
        bit got = 0;
        @(posedge ck); #1;
        req[i] = 1'b1;
        req_val[i*W +: W] = W'(v);
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge ck);
            if (grant[i]) got = 1;
        end
        chk("insert_granted", int'(got), 1);
        @(posedge ck); #1;
        req[i] = 1'b0;
    endtask

    task automatic pop_until_empty();
        @(posedge ck); #1;
        pop_req = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge ck);
            if (empty) break;
        end
        chk("drain_empty", int'(empty), 1);
        @(posedge ck); #1;
        pop_req = 1'b0;
    endtask

    task automatic settle();
        @(negedge ck); #1;
    endtask

    initial begin
        int acks;
        logic [NREQ-1:0] g;
        logic pa;
        r = 1'b0; req = '0; req_val = '0; pop_req = 1'b0; flush = 1'b0;
        #2 r = 1'b1;
        repeat (3) @(posedge ck);
        #1 r = 1'b0;

        // Reset then idle
        strobe_cnt = 0;
        repeat (10) @(posedge ck);
        settle();
        chk("idle_count", int'(count), 0);
        chk("idle_empty", int'(empty), 1);
        chk("idle_strobes", strobe_cnt, 0);

        // Sorted fill and drain
        pop_log.delete();
        do_insert(0, 5); do_insert(0, 9); do_insert(0, 2); do_insert(0, 7);
        settle();
        chk("fill_count", int'(count), 4);
        pop_until_empty();
        settle();
        chk("drain_n", pop_log.size(), 4);
        chk("drain_0", pop_log[0], 9);
        chk("drain_1", pop_log[1], 7);
        chk("drain_2", pop_log[2], 5);
        chk("drain_3", pop_log[3], 2);
        chk("drain_count", int'(count), 0);

        // Full backpressure
        do_insert(0, 3); do_insert(0, 8); do_insert(0, 1);
        do_insert(0, 6); do_insert(0, 4); do_insert(0, 2);
        settle();
        chk("full_flag", int'(full), 1);
        @(posedge ck); #1;
        req[1] = 1'b1; req_val[1*W +: W] = 8'd5; pop_req = 1'b1;
        @(negedge ck);
        chk("full_no_grant", int'(grant), 0);
        chk("full_pop_ack", int'(pop_ack), 1);
        @(posedge ck); #1;
        pop_req = 1'b0;
        @(negedge ck);
        chk("full_then_grant", int'(grant), 2);
        @(posedge ck); #1;
        req = '0;
        pop_until_empty();

        // Round-robin fairness from a fresh reset
        @(posedge ck); #3 r = 1'b1;
        @(posedge ck); #1 r = 1'b0;
        grant_log.delete();
        req_val = {8'd40, 8'd30, 8'd20, 8'd10};
        req = 4'hF;
        for (int n = 0; n < 30; n++) begin
            settle();
            if (grant_log.size() >= 5) break;
        end
        @(posedge ck); #1;
        req = '0;
        chk("rr_0", grant_log[0], 0);
        chk("rr_1", grant_log[1], 1);
        chk("rr_2", grant_log[2], 2);
        chk("rr_3", grant_log[3], 3);
        chk("rr_4", grant_log[4], 0);

        // Insert/pop contention starting from 3 held entries
        acks = 0;
        @(posedge ck); #1 pop_req = 1'b1;
        for (int n = 0; n < 20 && acks < 2; n++) begin
            @(negedge ck);
            if (pop_ack) acks++;
        end
        @(posedge ck); #1 pop_req = 1'b0;
        settle();
        chk("cont_start", int'(count), 3);
        op_log.delete();
        @(posedge ck); #1;
        req[2] = 1'b1; req_val[2*W +: W] = 8'd50; pop_req = 1'b1;
        repeat (6) @(negedge ck);
        #1;
        chk("cont_n", op_log.size(), 6);
        for (int k = 0; k < 6; k++) chk("cont_op", op_log[k], (k % 2 == 0) ? 1 : 2);
        @(posedge ck); #1;
        req = '0; pop_req = 1'b0;

        // Flush with count=4; a simultaneous request waits until after the clear
        do_insert(0, 77);
        settle();
        chk("flush_pre", int'(count), 4);
        clear_cnt = 0;
        @(posedge ck); #1;
        flush = 1'b1; req[0] = 1'b1; req_val[0 +: W] = 8'd33;
        @(negedge ck);
        chk("flush_c0_grant", int'(grant), 0);
        chk("flush_c0_clear", int'(pq_clear), 0);
        @(posedge ck); #1 flush = 1'b0;
        @(negedge ck);
        chk("flush_c1_clear", int'(pq_clear), 1);
        chk("flush_c1_grant", int'(grant), 0);
        @(posedge ck); #1;
        @(negedge ck);
        chk("flush_after_count", int'(count), 0);
        chk("flush_after_grant", int'(grant), 1);
        @(posedge ck); #1 req = '0;
        settle();
        chk("flush_clears", clear_cnt, 1);
        chk("flush_svc_count", int'(count), 1);

        // Zero-valued insert: granted, not loaded
        do_insert(1, 0);
        settle();
        chk("zero_count", int'(count), 1);

        // Asynchronous reset in the middle of a pop
        do_insert(0, 11);
        @(posedge ck); #1 pop_req = 1'b1;
        @(negedge ck);
        @(posedge ck); #2;
        chk("mid_pop_valid", int'(pop_valid), 1);
        r = 1'b1;
        #1;
        chk("arst_pop_valid", int'(pop_valid), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_pop_ack", int'(pop_ack), 0);
        chk("arst_shift", int'(pq_shiftOut), 0);
        pop_req = 1'b0;
        @(posedge ck); #1 r = 1'b0;

        // Randomized traffic obeying the hold-until-granted protocol
        for (int n = 0; n < 3000; n++) begin
            @(negedge ck);
            g = grant;
            pa = pop_ack;
            @(posedge ck); #1;
            req = req & ~g;
            if (pa) pop_req = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom % 3 == 0)) begin
                    req[i] = 1'b1;
                    req_val[i*W +: W] = ($urandom % 8 == 0) ? 8'd0 : W'($urandom_range(1, 255));
                end
            end
            if (!pop_req && ($urandom % 3 == 0)) pop_req = 1'b1;
            flush = ($urandom % 40 == 0);
        end
        @(posedge ck); #1;
        req = '0; pop_req = 1'b0; flush = 1'b0;
        repeat (3) settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
